// File: rtl/wavetable_pkg.sv
// Shared state encoding and width helpers for the wavetable playback bank.
package wavetable_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int mix_w(input int dw, input int n);
    return dw + ch_w(n);
  endfunction

endpackage

// File: rtl/wavetable_ram.sv
// Single-port sample RAM: byte-enabled write, registered read (1-cycle latency).
module wavetable_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 9
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/wavetable_bank.sv
// Multi-channel wavetable bank: host Avalon-MM port plus a per-tick phase
// engine that reads one sample per channel and emits their signed sum.
module wavetable_bank import wavetable_pkg::*; #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 24,
  localparam int CH_W    = ch_w(CHANNELS),
  localparam int MW      = mix_w(DATA_W, CHANNELS)
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [CH_W+ADDR_W-1:0]   s1_address,
  input  logic                     s1_chipselect,
  input  logic                     s1_write,
  input  logic [DATA_W-1:0]        s1_writedata,
  input  logic [DATA_W/8-1:0]      s1_byteenable,
  output logic [DATA_W-1:0]        s1_readdata,
  output logic                     s1_waitrequest,
  input  logic                     inc_wr,
  input  logic [CH_W-1:0]          inc_ch,
  input  logic [PHASE_W-1:0]       inc_data,
  input  logic [CHANNELS-1:0]      ch_enable,
  input  logic                     sample_tick,
  input  logic                     overrun_clr,
  output logic [MW-1:0]            mix_out,
  output logic                     mix_valid,
  output logic                     overrun
);

  logic [1:0]                          state;
  logic [CH_W-1:0]                     ch_cnt;
  logic [CHANNELS-1:0][PHASE_W-1:0]    phase, inc;
  logic                                eng_vld, eng_en;
  logic [MW-1:0]                       acc, contrib;
  logic                                host_rd;
  logic [DATA_W-1:0]                   rd_hold, ram_q;
  logic                                accept;
  logic [CH_W+ADDR_W-1:0]              ram_addr;

  assign s1_waitrequest = (state == S_READ);
  assign accept         = s1_chipselect && !s1_waitrequest;
  // The engine owns the RAM port only while reading; host uses it otherwise.
  assign ram_addr = s1_waitrequest ? {ch_cnt, phase[ch_cnt][PHASE_W-1 -: ADDR_W]}
                                   : s1_address;

  wavetable_ram #(.DATA_W(DATA_W), .AW(CH_W+ADDR_W)) u_ram (
    .clk   (clk_clk),
    .addr  (ram_addr),
    .we    (accept && s1_write),
    .be    (s1_byteenable),
    .wdata (s1_writedata),
    .q     (ram_q)
  );

  // Host read data comes straight from the RAM the cycle after acceptance,
  // then is held so later engine reads do not disturb it.
  assign s1_readdata = host_rd ? ram_q : rd_hold;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      host_rd <= 1'b0;
      rd_hold <= '0;
    end else begin
      host_rd <= accept && !s1_write;
      if (host_rd) rd_hold <= ram_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      phase <= '0;
      inc   <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (state == S_READ && ch_cnt == CH_W'(c) && ch_enable[c])
          phase[c] <= phase[c] + inc[c];
        if (inc_wr && inc_ch == CH_W'(c))
          inc[c] <= inc_data;
      end
    end
  end

  assign contrib = eng_en ? {{CH_W{ram_q[DATA_W-1]}}, ram_q} : '0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= S_IDLE;
      ch_cnt    <= '0;
      eng_vld   <= 1'b0;
      eng_en    <= 1'b0;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      eng_vld   <= (state == S_READ);
      eng_en    <= (state == S_READ) && ch_enable[ch_cnt];
      if (eng_vld) acc <= acc + contrib;
      case (state)
        S_IDLE: if (sample_tick) begin
          state  <= S_READ;
          ch_cnt <= '0;
          acc    <= '0;
        end
        S_READ: begin
          ch_cnt <= ch_cnt + 1'b1;
          if (ch_cnt == CH_W'(CHANNELS-1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          mix_out   <= acc + contrib;
          mix_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (sample_tick && state != S_IDLE) overrun <= 1'b1;
      else if (overrun_clr)               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wavetable_bank.sv
// Directed bench for wavetable_bank at default parameters (2 channels, 16-bit).
module tb_wavetable_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  addr;
  logic        cs, wr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic [15:0] rdata;
  logic        waitreq;
  logic        inc_wr;
  logic        inc_ch;
  logic [23:0] inc_data;
  logic [1:0]  ch_enable;
  logic        tick, oclr;
  logic [16:0] mix_out;
  logic        mix_valid, overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wavetable_bank dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .s1_address(addr), .s1_chipselect(cs), .s1_write(wr),
    .s1_writedata(wdata), .s1_byteenable(be),
    .s1_readdata(rdata), .s1_waitrequest(waitreq),
    .inc_wr(inc_wr), .inc_ch(inc_ch), .inc_data(inc_data),
    .ch_enable(ch_enable), .sample_tick(tick), .overrun_clr(oclr),
    .mix_out(mix_out), .mix_valid(mix_valid), .overrun(overrun)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [8:0] a, input logic [15:0] d, input logic [1:0] b);
    cs = 1; wr = 1; addr = a; wdata = d; be = b;
    step();
    cs = 0; wr = 0;
  endtask

  task automatic host_read(input logic [8:0] a, output logic [15:0] d);
    cs = 1; wr = 0; addr = a;
    step();
    cs = 0;
    d = rdata;
  endtask

  // Tick at cycle T; observe T+1..T+8 for mix_valid pulses.
  task automatic do_tick(output logic [16:0] val, output int at, output int pulses);
    val = '0; at = -1; pulses = 0;
    tick = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) tick = 0;
      if (mix_valid) begin
        pulses++;
        if (at < 0) begin at = k; val = mix_out; end
      end
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [8:0]  a;
    logic [15:0] d;
    logic [1:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [15:0] rd;
    logic [16:0] mv;
    int at, np;

    rst_n = 0; cs = 0; wr = 0; addr = '0; wdata = '0; be = '0;
    inc_wr = 0; inc_ch = 0; inc_data = '0; ch_enable = 2'b11; tick = 0; oclr = 0;
    repeat (3) step();
    rst_n = 1;
    step();
    chk("rst_readdata", 32'(rdata), 0);
    chk("rst_waitreq", 32'(waitreq), 0);
    chk("rst_mix_out", 32'(mix_out), 0);
    chk("rst_mix_valid", 32'(mix_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);

    vt[0] = '{1, 9'h005, 16'h1234, 2'b11, 16'h0, "wr_05_full"};
    vt[1] = '{0, 9'h005, 16'h0,    2'b00, 16'h1234, "rd_05_full"};
    vt[2] = '{1, 9'h005, 16'hABCD, 2'b01, 16'h0, "wr_05_lo"};
    vt[3] = '{0, 9'h005, 16'h0,    2'b00, 16'h12CD, "rd_05_lo"};
    vt[4] = '{1, 9'h105, 16'h5555, 2'b11, 16'h0, "wr_105_full"};
    vt[5] = '{1, 9'h105, 16'hAAAA, 2'b10, 16'h0, "wr_105_hi"};
    vt[6] = '{0, 9'h105, 16'h0,    2'b00, 16'hAA55, "rd_105_hi"};
    for (int i = 0; i < 7; i++) begin
      if (vt[i].is_wr) host_write(vt[i].a, vt[i].d, vt[i].b);
      else begin
        host_read(vt[i].a, rd);
        chk(vt[i].name, 32'(rd), 32'(vt[i].exp));
      end
    end
    step();
    chk("rd_hold", 32'(rdata), 32'h0000AA55);

    // Mix sum of full-scale positive samples.
    host_write(9'h000, 16'h7FFF, 2'b11);
    host_write(9'h100, 16'h7FFF, 2'b11);
    ch_enable = 2'b11;
    do_tick(mv, at, np);
    chk("mix_lat", 32'(at), 4);
    chk("mix_pulses", 32'(np), 1);
    chk("mix_sum11", 32'(mv), 32'h0FFFE);
    chk("mix_hold", 32'(mix_out), 32'h0FFFE);
    ch_enable = 2'b01;
    do_tick(mv, at, np);
    chk("mix_sum01", 32'(mv), 32'h07FFF);

    // Half-table increment on ch0 alternates idx0 / idx128.
    host_write(9'h000, 16'h0001, 2'b11);
    host_write(9'h080, 16'h0002, 2'b11);
    inc_wr = 1; inc_ch = 0; inc_data = 24'h800000;
    step();
    inc_wr = 0;
    for (int i = 0; i < 4; i++) begin
      do_tick(mv, at, np);
      chk($sformatf("wrap_%0d", i), 32'(mv), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Host write stalled by READ, plus a tick that overruns.
    tick = 1;
    step();                       // T+1
    tick = 0;
    cs = 1; wr = 1; addr = 9'h005; wdata = 16'hBEEF; be = 2'b11;
    chk("stall_t1", 32'(waitreq), 1);
    step();                       // T+2
    chk("stall_t2", 32'(waitreq), 1);
    tick = 1;
    step();                       // T+3 (DRAIN)
    tick = 0;
    chk("stall_t3", 32'(waitreq), 0);
    chk("overrun_set", 32'(overrun), 1);
    step();                       // T+4
    cs = 0; wr = 0;
    np = 0;
    if (mix_valid) np++;
    chk("stall_mix_at4", 32'(mix_valid), 1);
    chk("stall_mix_val", 32'(mix_out), 1);
    for (int k = 0; k < 6; k++) begin
      step();
      if (mix_valid) np++;
    end
    chk("overrun_no_extra", 32'(np), 1);
    host_read(9'h005, rd);
    chk("stall_write_landed", 32'(rd), 32'hBEEF);
    oclr = 1;
    step();
    oclr = 0;
    chk("overrun_clr", 32'(overrun), 0);

    // Set and clear on the same edge: set wins.
    tick = 1;
    step();
    tick = 1; oclr = 1;
    step();
    tick = 0; oclr = 0;
    chk("overrun_set_wins", 32'(overrun), 1);
    repeat (6) step();
    oclr = 1;
    step();
    oclr = 0;

    // ch0 phase now 0; one tick advances it to half-table.
    do_tick(mv, at, np);
    chk("pre_rst_mix", 32'(mv), 1);

    // Reset mid-READ.
    tick = 1;
    step();                       // T+1
    tick = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    np = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (mix_valid) np++;
    end
    chk("midrst_no_valid", 32'(np), 0);
    chk("midrst_mix_out", 32'(mix_out), 0);
    chk("midrst_waitreq", 32'(waitreq), 0);
    do_tick(mv, at, np);
    chk("midrst_phase0_a", 32'(mv), 1);
    do_tick(mv, at, np);
    chk("midrst_phase0_b", 32'(mv), 1);
    host_read(9'h005, rd);
    chk("midrst_table_kept", 32'(rd), 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wavetable_bank.md
# wavetable_bank

Multi-channel wavetable playback memory for the synthesizer datapath. It is the parametrised successor to the fixed pair of 256×16 on-chip sample memories. It stores CHANNELS tables of 2^ADDR_W signed samples behind one Avalon-MM slave port. On each sample tick, a phase-accumulator engine walks every channel, reads one sample per channel and emits their signed sum to the codec path.

## Interface
- DATA_W, 16: sample width; multiple of 8.
- ADDR_W, 8: log2 of table depth per channel.
- CHANNELS, 2: channel count; power of two, ≥2. CH_W = log2(CHANNELS).
- PHASE_W, 24: phase accumulator width; must be > ADDR_W.

- clk_clk  in  1  sole clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- s1_address  in  CH_W+ADDR_W  {channel, index}.
- s1_chipselect  in  1  access request.
- s1_write  in  1  1 = write, 0 = read.
- s1_writedata  in  DATA_W  write data.
- s1_byteenable  in  DATA_W/8  per-byte write enable.
- s1_readdata  out  DATA_W  read data, valid the cycle after acceptance.
- s1_waitrequest  out  1  host access stalled this cycle.
- inc_wr  in  1  load phase increment.
- inc_ch  in  CH_W  target channel.
- inc_data  in  PHASE_W  increment value.
- ch_enable  in  CHANNELS  per-channel enable.
- sample_tick  in  1  one-cycle pulse per output sample.
- overrun_clr  in  1  clears overrun.
- mix_out  out  DATA_W+CH_W  signed sum of channel samples.
- mix_valid  out  1  one-cycle pulse; mix_out updated.
- overrun  out  1  sticky: tick arrived while busy.

## Operation
- Storage: one single-port RAM of CHANNELS·2^ADDR_W words, address {ch, idx}, 1-cycle read latency. RAM contents are not reset.
- Host access: accepted when chipselect=1 and waitrequest=0.
  - Write: updates only the enabled bytes.
  - Read: s1_readdata is valid the next cycle and holds until the next accepted read.
- FSM states:
  - IDLE → READ on sample_tick.
  - READ: one channel per cycle, c = 0..CHANNELS-1. RAM address = {c, phase[c][PHASE_W-1 -: ADDR_W]}. Enabled channel: phase[c] <= phase[c] + inc[c] mod 2^PHASE_W. Disabled channel: phase held.
  - READ → DRAIN after c = CHANNELS-1.
  - DRAIN: the last read datum is accumulated; mix_out is registered.
  - DRAIN → IDLE.
- Accumulation: each returned sample is sign-extended to DATA_W+CH_W. A disabled channel contributes 0. Sum is cleared at READ entry. Overflow cannot occur.
- s1_waitrequest = (state == READ). The RAM port is free in IDLE and DRAIN.
- inc_wr may occur in any state. If it lands on the same edge as channel c's advance, the old inc is used for that advance.
- sample_tick in READ or DRAIN: ignored and sets overrun. overrun_clr clears overrun. If set and clear coincide, set wins.
- Reset (any state, including mid-READ):
  - State → IDLE.
  - phase, inc, mix_out, s1_readdata, mix_valid, overrun, accumulator all → 0.
  - s1_waitrequest → 0.

## Timing
- sample_tick high in cycle T:
  - READ occupies cycles T+1..T+CHANNELS.
  - DRAIN occupies cycle T+CHANNELS+1.
  - mix_valid is high for exactly cycle T+CHANNELS+2.
  - Latency = CHANNELS+2 cycles.
- Minimum tick spacing without overrun: CHANNELS+2 cycles.
- A host access in cycle T (tick cycle) completes normally. Its read data appears in T+1, while the engine owns the port.
- A host access stalled in READ completes in the first DRAIN cycle.
- mix_out holds between mix_valid pulses.

## Structure
- Package wavetable_pkg holds:
  - The state enum (IDLE, READ, DRAIN).
  - The CH_W/width helper functions.
- Sub-module wavetable_ram: single-port RAM with byte enables and 1-cycle registered read, instantiated once.
- Phase and inc register arrays, accumulator and FSM live in the top level.

## Test plan
All scenarios use defaults: CHANNELS=2, DATA_W=16, ADDR_W=8, PHASE_W=24.
- Reset: after reset release, all outputs are 0 and s1_waitrequest=0.
- Byte enables:
  - Write {0,5} = 0x1234 with be=11 → read returns 0x1234 one cycle after accept.
  - Write 0xABCD with be=01 → read returns 0x12CD.
- Mix sum: tables idx0 = 0x7FFF on both channels, inc=0, ch_enable=11, tick at T → mix_valid only at T+4, mix_out = 0x0FFFE. With ch_enable=01 → 0x07FFF.
- Phase wrap: inc[0] = 0x800000, ch0 idx0 = 1, idx128 = 2, ch1 disabled → successive mix_out values 1, 2, 1, 2.
- Stall and overrun:
  - Host write issued in T+1 → waitrequest high in T+1..T+2; write lands in T+3.
  - Tick at T+2 → overrun=1 and no extra mix_valid.
  - overrun_clr → overrun=0.
- Mid-operation reset: assert reset_reset_n=0 in T+1 → no mix_valid, phases 0, previously written table data still readable.
